// File: rtl/quotient_bcd_pkg.sv
// rtl/quotient_bcd_pkg.sv - shared constants and state type for the quotient BCD converter
//
// Purpose: default widths, the divider error code and the converter FSM state
// encoding, imported by the converter top and its helpers.
// Ports: none (package).

package quotient_bcd_pkg;

  localparam int DEFAULT_WORD_WIDTH = 32;
  localparam int DEFAULT_DIGITS     = 10;

  // Error code the divider places on its quotient output; shared with the divider.
  localparam logic [31:0] ERR_CODE = 32'h0BAD1DEA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/quotient_bcd_converter_bcd_digit_adjust.sv
// rtl/quotient_bcd_converter_bcd_digit_adjust.sv - double-dabble add-3 correction for one BCD digit
//
// Purpose: out = in >= 5 ? in + 3 : in. Inputs 5..9 map to 8..12, so the sum
// never leaves the 4-bit digit; the following left shift carries it onward.
// Ports:
//   i_digit  in  4  BCD digit before correction
//   o_digit  out 4  corrected digit

module bcd_digit_adjust (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/quotient_bcd_converter.sv
// rtl/quotient_bcd_converter.sv - change-triggered iterative binary-to-BCD converter for the divider quotient
//
// Purpose: watches the free-running quotient, and whenever it differs from the
// last converted value captures it and runs a one-bit-per-clock double dabble,
// then presents packed BCD digits with a one-cycle valid strobe.
// Optional feature macro: QUOTIENT_BCD_ERRFLAG_EN - when defined, the divider
// error code bypasses conversion and is reported as all-F digits plus o_error.
// Ports:
//   i_clk     in  1             clock, rising edge
//   i_rst_n   in  1             asynchronous active-low reset
//   i_result  in  WORD_WIDTH    quotient level from the divider (no qualifier)
//   o_bcd     out 4*DIGITS      packed BCD, digit 0 in bits [3:0]
//   o_valid   out 1             one-cycle pulse when o_bcd/o_error update
//   o_busy    out 1             high from capture edge until o_valid issues
//   o_error   out 1             last conversion was the divider error code

module quotient_bcd_converter
  import quotient_bcd_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int DIGITS     = DEFAULT_DIGITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [WORD_WIDTH-1:0] i_result,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_error
);

  localparam int CNT_W = $clog2(WORD_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] bin_sr_q, bin_sr_d;
  logic [WORD_WIDTH-1:0] captured_q, captured_d;
  logic [WORD_WIDTH-1:0] last_value_q, last_value_d;
  logic [4*DIGITS-1:0]   bcd_acc_q, bcd_acc_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic [4*DIGITS-1:0]   bcd_adj;

  // Add-3 correction on every digit of the accumulator before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (bcd_acc_q[4*g +: 4]),
      .o_digit (bcd_adj[4*g +: 4])
    );
  end

`ifdef QUOTIENT_BCD_ERRFLAG_EN
  logic error_q, error_d;
  logic err_hit_q, err_hit_d;
`endif

  always_comb begin
    state_d      = state_q;
    bin_sr_d     = bin_sr_q;
    captured_d   = captured_q;
    last_value_d = last_value_q;
    bcd_acc_d    = bcd_acc_q;
    bit_cnt_d    = bit_cnt_q;
    bcd_d        = bcd_q;
    valid_d      = 1'b0;
    busy_d       = busy_q;
`ifdef QUOTIENT_BCD_ERRFLAG_EN
    error_d      = error_q;
    err_hit_d    = err_hit_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_result != last_value_q) begin
          captured_d = i_result;
          bin_sr_d   = i_result;
          bcd_acc_d  = '0;
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
`ifdef QUOTIENT_BCD_ERRFLAG_EN
          err_hit_d  = 1'b0;
          if (i_result == WORD_WIDTH'(ERR_CODE)) begin
            err_hit_d = 1'b1;
            state_d   = ST_DONE;
          end
`endif
        end
      end

      ST_SHIFT: begin
        bcd_acc_d = {bcd_adj[4*DIGITS-2:0], bin_sr_q[WORD_WIDTH-1]};
        bin_sr_d  = {bin_sr_q[WORD_WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        bcd_d        = bcd_acc_q;
        valid_d      = 1'b1;
        busy_d       = 1'b0;
        last_value_d = captured_q;
        state_d      = ST_IDLE;
`ifdef QUOTIENT_BCD_ERRFLAG_EN
        error_d = err_hit_q;
        if (err_hit_q) begin
          bcd_d = '1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      bin_sr_q     <= '0;
      captured_q   <= '0;
      last_value_q <= '0;
      bcd_acc_q    <= '0;
      bit_cnt_q    <= '0;
      bcd_q        <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_sr_q     <= bin_sr_d;
      captured_q   <= captured_d;
      last_value_q <= last_value_d;
      bcd_acc_q    <= bcd_acc_d;
      bit_cnt_q    <= bit_cnt_d;
      bcd_q        <= bcd_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

`ifdef QUOTIENT_BCD_ERRFLAG_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      error_q   <= 1'b0;
      err_hit_q <= 1'b0;
    end else begin
      error_q   <= error_d;
      err_hit_q <= err_hit_d;
    end
  end

  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

  assign o_bcd   = bcd_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule
